inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Instruction-fetch controller for the pipelined CPU. It owns the PC and sequences the combinational 64-word instruction ROM. It drives the IF/ID pipeline register, handling load-use stalls, branch redirects with flush, run/single-step control and a terminal halt address. It sits between the instruction ROM and the ID stage, replacing the free-running PC register.

## Interface
- PC_RESET, 32'h0000_0000: PC value after reset.
- HALT_PC, 32'h0000_00FC: byte address whose delivery ends execution.
- clk  in  1  clock; all state changes on the rising edge.
- clrn  in  1  asynchronous, active-low reset.
- rom_a  out  6  ROM word address, combinational: pc[7:2].
- rom_inst  in  32  ROM data, combinational from rom_a.
- run  in  1  level; 1 = free-running fetch.
- step  in  1  single-cycle pulse; fetch exactly one instruction.
- stall  in  1  load-use stall from ID; hold PC and IF/ID.
- br_taken  in  1  branch resolved taken in ID.
- br_target  in  32  branch target byte address.
- pc  out  32  current fetch PC.
- if_id_inst  out  32  instruction presented to ID; 32'h0 (nop) on bubble.
- if_id_pc4  out  32  pc+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- state  out  2  controller state.
- fetch_cnt  out  16  delivered-instruction count, saturating.

## Operation
- States: IDLE=0, RUN=1, STEP=2, DONE=3.
- Delivery in RUN or STEP when not stalled and no branch:
  - if_id_inst<=rom_inst; if_id_pc4<=pc+4; if_id_valid<=1.
  - pc<=pc+4; fetch_cnt+1, saturating at 16'hFFFF.
- Per-cycle priority, highest first:
  - DONE: hold pc; insert bubble; ignore run, step, br_taken and stall.
  - br_taken, in IDLE/RUN/STEP: pc<=br_target; IF/ID flushed to bubble (inst=0, pc4=0, valid=0); no delivery; state unchanged. Branch beats a simultaneous stall.
  - stall: pc, IF/ID, fetch_cnt and state all hold.
  - IDLE: pc holds; insert bubble. run=1 -> RUN; else step=1 -> STEP. Both asserted: RUN.
  - RUN: deliver. run=0 -> IDLE after this cycle's delivery.
  - STEP: deliver, then -> IDLE. A stalled or branch-redirected STEP stays STEP until one delivery completes.
- Halt: a delivery with pc==HALT_PC moves to DONE (from RUN or STEP). That instruction is still delivered with valid=1.
- Arithmetic and width:
  - pc+4 wraps modulo 2^32.
  - rom_a uses pc[7:2] only, so targets beyond 0xFF alias modulo 64 words.
  - pc[1:0] of br_target is stored but ignored for addressing.
- Reset: clrn low at any time, including mid-stall or mid-step, immediately forces:
  - pc=PC_RESET, state=IDLE.
  - if_id_inst=0, if_id_pc4=0, if_id_valid=0.
  - fetch_cnt=0.

## Timing
- rom_a follows pc combinationally. The ROM has zero latency and is sampled at the same edge that advances pc.
- Fetch-to-ID latency: 1 cycle. PC value p at edge k gives rom[p[7:2]] in if_id_inst after edge k.
- Throughput: 1 instruction/cycle in RUN without stall or branch.
- Branch penalty: 1 bubble. The target instruction appears 2 edges after br_taken is sampled.
- stall held N cycles freezes outputs for N cycles; delivery resumes on the first unstalled edge.
- step is edge-sampled; only the cycle it is high in IDLE counts.
- DONE exits only via clrn.

## Structure
- Shared package fetch_pkg:
  - state encodings IDLE/RUN/STEP/DONE.
  - NOP_INST=32'h0.
  - PC width constant 32; ROM index width constant 6.
- One sub-module, fetch_pc_sel: combinational next-PC mux (hold / pc+4 / br_target), with select derived from state, stall and br_taken.
- Top: state register, pc register, IF/ID register, counter.

## Test plan
- Reset and run, with ROM word i = 32'h1000_0000+i:
  - clrn low -> all outputs 0, state 0, pc=0.
  - Release and raise run -> if_id_inst 32'h1000_0000, 32'h1000_0001, ... on consecutive cycles; fetch_cnt counts 1, 2, 3.
- Stall: assert stall 3 cycles while pc=0x0C -> pc, if_id_inst=32'h1000_0002 and fetch_cnt frozen 3 cycles; then 32'h1000_0003 delivered.
- Branch with stall: br_taken=1, stall=1, br_target=0x30 at pc=0x10 -> next cycle valid=0 and inst=0, pc=0x30; following cycle inst=32'h1000_000C.
- Single step: from IDLE pulse step -> exactly one delivery, state 2 then 0. Pulse step together with stall for 2 cycles -> delivery only after stall drops.
- Halt: HALT_PC=0x14, run=1 from reset -> word 5 delivered valid, state=3. Afterwards bubbles only; run, step and br_taken ignored; fetch_cnt stays 6.
- Mid-run reset: assert clrn low at pc=0x20 during a stall -> asynchronous clear of all outputs before the next edge; restart fetches from 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
`timescale 1ns/1ps
package fetch_pkg;
    localparam int PC_W   = 32;
    localparam int ROM_AW = 6;
    localparam logic [31:0] NOP_INST = 32'h0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_INC  = 2'd1,
        SEL_BR   = 2'd2
    } pc_sel_e;
endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC mux: hold, sequential pc+4, or branch redirect.
`timescale 1ns/1ps
module fetch_pc_sel
    import fetch_pkg::*;
(
    input  state_e          state,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] br_target,
    output pc_sel_e         sel,
    output logic [PC_W-1:0] pc_next
);
    always_comb begin
        sel = SEL_HOLD;
        // A halted core ignores redirects; a branch beats a stall.
        if (state != S_DONE) begin
            if (br_taken)
                sel = SEL_BR;
            else if (!stall && (state == S_RUN || state == S_STEP))
                sel = SEL_INC;
        end
        case (sel)
            SEL_INC: pc_next = pc + PC_W'(4);
            SEL_BR:  pc_next = br_target;
            default: pc_next = pc;
        endcase
    end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: PC, run/step/halt sequencing and the IF/ID register.
`timescale 1ns/1ps
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] HALT_PC  = 32'h0000_00FC
) (
    input  logic              clk,
    input  logic              clrn,
    output logic [ROM_AW-1:0] rom_a,
    input  logic [31:0]       rom_inst,
    input  logic              run,
    input  logic              step,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    output logic [PC_W-1:0]   pc,
    output logic [31:0]       if_id_inst,
    output logic [PC_W-1:0]   if_id_pc4,
    output logic              if_id_valid,
    output logic [1:0]        state,
    output logic [15:0]       fetch_cnt
);
    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_next;
    logic [31:0]       inst_q, inst_d;
    logic [PC_W-1:0]   pc4_q, pc4_d;
    logic              valid_q, valid_d;
    logic [15:0]       cnt_q, cnt_d;
    pc_sel_e           sel;

    fetch_pc_sel u_pc_sel (
        .state     (state_q),
        .stall     (stall),
        .br_taken  (br_taken),
        .pc        (pc_q),
        .br_target (br_target),
        .sel       (sel),
        .pc_next   (pc_next)
    );

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (sel == SEL_INC) begin
            inst_d  = rom_inst;
            pc4_d   = pc_q + PC_W'(4);
            valid_d = 1'b1;
            cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            if (pc_q == HALT_PC)
                state_d = S_DONE;
            else if (state_q == S_STEP || !run)
                state_d = S_IDLE;
        end else if (state_q == S_DONE || sel == SEL_BR || (state_q == S_IDLE && !stall)) begin
            inst_d  = NOP_INST;
            pc4_d   = '0;
            valid_d = 1'b0;
            // Only an unstalled, unredirected IDLE cycle may start fetching.
            if (state_q == S_IDLE && sel != SEL_BR) begin
                if (run)
                    state_d = S_RUN;
                else if (step)
                    state_d = S_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            inst_q  <= NOP_INST;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_next;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rom_a       = pc_q[7:2];
    assign pc          = pc_q;
    assign if_id_inst  = inst_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign state       = state_q;
    assign fetch_cnt   = cnt_q;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a cycle-level reference model and literal spot checks.
`timescale 1ns/1ps
module tb_inst_fetch_ctrl;
    localparam logic [31:0] HALT = 32'h0000_0014;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [5:0]  rom_a;
    logic [31:0] rom_inst;
    logic        run = 1'b0, step = 1'b0, stall = 1'b0, br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [31:0] pc, if_id_inst, if_id_pc4;
    logic        if_id_valid;
    logic [1:0]  state;
    logic [15:0] fetch_cnt;

    logic [31:0] rom [64];
    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Reference model state
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_vld;
    logic [1:0]  m_st;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    assign rom_inst = rom[rom_a];

    inst_fetch_ctrl #(.PC_RESET(32'h0), .HALT_PC(HALT)) dut (
        .clk(clk), .clrn(clrn), .rom_a(rom_a), .rom_inst(rom_inst),
        .run(run), .step(step), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .pc(pc), .if_id_inst(if_id_inst),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .state(state),
        .fetch_cnt(fetch_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0=IDLE 1=RUN 2=STEP 3=DONE, priority DONE > branch > stall > state action.
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_pc <= 32'h0; m_st <= 2'd0; m_inst <= 32'h0; m_pc4 <= 32'h0; m_vld <= 1'b0; m_cnt <= 16'h0;
        end else if (m_st == 2'd3) begin
            m_inst <= 32'h0; m_pc4 <= 32'h0; m_vld <= 1'b0;
        end else if (br_taken) begin
            m_pc <= br_target; m_inst <= 32'h0; m_pc4 <= 32'h0; m_vld <= 1'b0;
        end else if (stall) begin
            m_pc <= m_pc;
        end else if (m_st == 2'd0) begin
            m_inst <= 32'h0; m_pc4 <= 32'h0; m_vld <= 1'b0;
            if (run) m_st <= 2'd1;
            else if (step) m_st <= 2'd2;
        end else begin
            m_inst <= rom[m_pc[7:2]];
            m_pc4  <= m_pc + 32'd4;
            m_vld  <= 1'b1;
            m_pc   <= m_pc + 32'd4;
            if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            if (m_pc == HALT)       m_st <= 2'd3;
            else if (m_st == 2'd2)  m_st <= 2'd0;
            else                    m_st <= run ? 2'd1 : 2'd0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("pc", pc, m_pc);
            check("rom_a", {26'h0, rom_a}, {26'h0, m_pc[7:2]});
            check("inst", if_id_inst, m_inst);
            check("pc4", if_id_pc4, m_pc4);
            check("valid", {31'h0, if_id_valid}, {31'h0, m_vld});
            check("state", {30'h0, state}, {30'h0, m_st});
            check("cnt", {16'h0, fetch_cnt}, {16'h0, m_cnt});
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;
        tick(2);
        started = 1'b1;
        check("rst_pc", pc, 32'h0);
        check("rst_state", {30'h0, state}, 32'h0);
        check("rst_valid", {31'h0, if_id_valid}, 32'h0);
        check("rst_cnt", {16'h0, fetch_cnt}, 32'h0);

        // Free-running fetch
        clrn = 1'b1; run = 1'b1;
        tick(); check("run_state", {30'h0, state}, 32'h1);
        tick(); check("w0", if_id_inst, 32'h1000_0000); check("cnt1", {16'h0, fetch_cnt}, 32'd1);
        tick(); check("w1", if_id_inst, 32'h1000_0001); check("pc4_1", if_id_pc4, 32'h8);
        tick(); check("w2", if_id_inst, 32'h1000_0002); check("cnt3", {16'h0, fetch_cnt}, 32'd3);

        // Three-cycle stall at pc=0x0C
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("stall_pc", pc, 32'h0C); check("stall_inst", if_id_inst, 32'h1000_0002);
        end
        stall = 1'b0;
        tick(); check("w3", if_id_inst, 32'h1000_0003); check("pc10", pc, 32'h10);

        // Branch beats simultaneous stall
        br_taken = 1'b1; stall = 1'b1; br_target = 32'h30;
        tick(); check("br_valid", {31'h0, if_id_valid}, 32'h0); check("br_pc", pc, 32'h30);
        check("br_inst", if_id_inst, 32'h0);
        br_taken = 1'b0; stall = 1'b0;
        tick(); check("br_tgt_inst", if_id_inst, 32'h1000_000C);

        // Drop run: one more delivery then IDLE
        run = 1'b0;
        tick(); check("run_off_inst", if_id_inst, 32'h1000_000D); check("run_off_st", {30'h0, state}, 32'h0);
        tick(); check("idle_bubble", {31'h0, if_id_valid}, 32'h0);

        // Single step
        step = 1'b1;
        tick(); check("step_st", {30'h0, state}, 32'h2);
        step = 1'b0;
        tick(); check("step_inst", if_id_inst, 32'h1000_000E); check("step_idle", {30'h0, state}, 32'h0);
        tick(); check("step_once", pc, 32'h3C);

        // Step then stall for two cycles
        step = 1'b1;
        tick();
        step = 1'b0; stall = 1'b1;
        tick(2); check("stepst_hold", {30'h0, state}, 32'h2); check("stepst_pc", pc, 32'h3C);
        stall = 1'b0;
        tick(); check("stepst_inst", if_id_inst, 32'h1000_000F); check("stepst_idle", {30'h0, state}, 32'h0);

        // Halt at 0x14 from reset
        clrn = 1'b0;
        tick();
        clrn = 1'b1; run = 1'b1;
        tick(7);
        check("halt_st", {30'h0, state}, 32'h3); check("halt_inst", if_id_inst, 32'h1000_0005);
        check("halt_valid", {31'h0, if_id_valid}, 32'h1); check("halt_cnt", {16'h0, fetch_cnt}, 32'd6);
        br_taken = 1'b1; br_target = 32'h40; step = 1'b1;
        tick(); stall = 1'b1;
        tick(2);
        check("done_valid", {31'h0, if_id_valid}, 32'h0); check("done_cnt", {16'h0, fetch_cnt}, 32'd6);
        check("done_st", {30'h0, state}, 32'h3); check("done_pc", pc, 32'h18);

        // Async reset mid-stall at pc=0x20
        clrn = 1'b0;
        tick();
        clrn = 1'b1; run = 1'b0; step = 1'b0; stall = 1'b0; br_taken = 1'b1; br_target = 32'h20;
        tick(); br_taken = 1'b0; run = 1'b1;
        tick(); stall = 1'b1;
        tick(); check("pre_rst_pc", pc, 32'h20);
        #2 clrn = 1'b0;
        #1;
        check("arst_pc", pc, 32'h0); check("arst_inst", if_id_inst, 32'h0);
        check("arst_st", {30'h0, state}, 32'h0); check("arst_cnt", {16'h0, fetch_cnt}, 32'h0);
        tick();
        clrn = 1'b1; stall = 1'b0;
        tick(2); check("restart_w0", if_id_inst, 32'h1000_0000);
        tick(); check("restart_w1", if_id_inst, 32'h1000_0001);

        started = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
